// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the decoded control bundle carried between
// stages, its all-zero bubble value and a saturating counter helper.
package pipeline_pkg;

    localparam int ALU_CTRL_W = 3;

    typedef struct packed {
        logic                  reg_write;
        logic                  alu_src;
        logic                  mem_write;
        logic                  result_src;
        logic                  branch;
        logic [ALU_CTRL_W-1:0] alu_control;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard detector. Flags when the instruction in execute is a load
// whose destination is a source the decode instruction actually reads.
// Purely combinational so the forwarding unit can share it.
module load_use_detector #(
    parameter int REG_AW = 4
) (
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_result_src,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    output logic              hz
);

    logic ex_is_load;
    logic rs1_match;
    logic rs2_match;

    // Register zero is compared like any other register.
    always_comb begin
        ex_is_load = ex_valid & ex_reg_write & ex_result_src;
        rs1_match  = id_use_rs1 & (id_rs1 == ex_rd);
        rs2_match  = id_use_rs2 & (id_rs2 == ex_rd);
        hz         = ex_is_load & (rs1_match | rs2_match);
    end

endmodule

// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with load-use bubble insertion, branch
// flush and execute back-pressure hold.
// Optional performance counters are compiled in with DECODE_EXECUTE_PERF_EN.
//
// Handshake: a decode instruction is transferred on a rising edge where
// id_valid & id_ready are both 1 and flush is 0. id_ready is combinational,
// never depends on id_valid, and is 1 during flush because the decode
// instruction is then consumed and discarded. Toward execute, ex_valid=1 with
// ex_ready=0 holds every ex_* output stable until ex_ready rises.
module decode_execute_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic                  id_reg_write,
    input  logic                  id_alu_src,
    input  logic                  id_mem_write,
    input  logic                  id_result_src,
    input  logic                  id_branch,
    input  logic [ALU_CTRL_W-1:0] id_alu_control,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm_ext,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_alu_src,
    output logic                  ex_mem_write,
    output logic                  ex_result_src,
    output logic                  ex_branch,
    output logic [ALU_CTRL_W-1:0] ex_alu_control,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm_ext,
    output logic [REG_AW-1:0]     ex_rs1,
    output logic [REG_AW-1:0]     ex_rs2,
    output logic [REG_AW-1:0]     ex_rd
`ifdef DECODE_EXECUTE_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_bubble_cnt
`endif
);

    ctrl_bundle_t ctrl_q;
    ctrl_bundle_t id_ctrl;
    logic         valid_q;
    logic         hz;
    logic         adv;
    logic         load_bubble;

    load_use_detector #(
        .REG_AW(REG_AW)
    ) u_load_use_detector (
        .ex_valid     (valid_q),
        .ex_reg_write (ctrl_q.reg_write),
        .ex_result_src(ctrl_q.result_src),
        .ex_rd        (ex_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .hz           (hz)
    );

    // Advance, ready and bubble decisions for the coming edge.
    always_comb begin
        id_ctrl.reg_write   = id_reg_write;
        id_ctrl.alu_src     = id_alu_src;
        id_ctrl.mem_write   = id_mem_write;
        id_ctrl.result_src  = id_result_src;
        id_ctrl.branch      = id_branch;
        id_ctrl.alu_control = id_alu_control;
        adv         = ex_ready | ~valid_q;
        id_ready    = ~rst & (flush | (~hz & adv));
        load_bubble = flush | (adv & (hz | ~id_valid));
    end

    // Pipeline register: rst > flush > hold > hazard bubble > capture > empty bubble.
    // Bubbles clear only valid and controls; data and addresses keep their value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_BUBBLE;
            ex_pc      <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm_ext <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
        end else if (!adv) begin
            valid_q <= valid_q;
        end else if (hz || !id_valid) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
        end else begin
            valid_q    <= 1'b1;
            ctrl_q     <= id_ctrl;
            ex_pc      <= id_pc;
            ex_rd1     <= id_rd1;
            ex_rd2     <= id_rd2;
            ex_imm_ext <= id_imm_ext;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
        end
    end

    always_comb begin
        ex_valid       = valid_q;
        ex_reg_write   = ctrl_q.reg_write;
        ex_alu_src     = ctrl_q.alu_src;
        ex_mem_write   = ctrl_q.mem_write;
        ex_result_src  = ctrl_q.result_src;
        ex_branch      = ctrl_q.branch;
        ex_alu_control = ctrl_q.alu_control;
    end

`ifdef DECODE_EXECUTE_PERF_EN
    // Saturating event counters for stalls, flushes and bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (hz && adv)   perf_stall_cnt  <= sat_inc(perf_stall_cnt);
            if (flush)       perf_flush_cnt  <= sat_inc(perf_flush_cnt);
            if (load_bubble) perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage: reset, streaming, load-use stall,
// non-use, back-pressure, flush priority and reset mid-stream.
// Counter checks are included when DECODE_EXECUTE_PERF_EN is defined.
module tb_decode_execute_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic              id_ready;
    logic              id_reg_write;
    logic              id_alu_src;
    logic              id_mem_write;
    logic              id_result_src;
    logic              id_branch;
    logic [2:0]        id_alu_control;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm_ext;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              flush;
    logic              ex_ready;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_alu_src;
    logic              ex_mem_write;
    logic              ex_result_src;
    logic              ex_branch;
    logic [2:0]        ex_alu_control;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm_ext;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
`ifdef DECODE_EXECUTE_PERF_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_flush_cnt;
    logic [31:0]       perf_bubble_cnt;
`endif

    int tests;
    int fails;

    decode_execute_stage #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_reg_write  (id_reg_write),
        .id_alu_src    (id_alu_src),
        .id_mem_write  (id_mem_write),
        .id_result_src (id_result_src),
        .id_branch     (id_branch),
        .id_alu_control(id_alu_control),
        .id_pc         (id_pc),
        .id_rd1        (id_rd1),
        .id_rd2        (id_rd2),
        .id_imm_ext    (id_imm_ext),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_alu_src    (ex_alu_src),
        .ex_mem_write  (ex_mem_write),
        .ex_result_src (ex_result_src),
        .ex_branch     (ex_branch),
        .ex_alu_control(ex_alu_control),
        .ex_pc         (ex_pc),
        .ex_rd1        (ex_rd1),
        .ex_rd2        (ex_rd2),
        .ex_imm_ext    (ex_imm_ext),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd)
`ifdef DECODE_EXECUTE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic [31:0] pc, input logic [3:0] rd,
                               input logic [3:0] rs1, input logic u1,
                               input logic [3:0] rs2, input logic u2,
                               input logic rw, input logic rsrc, input logic mw);
        id_valid       = 1'b1;
        id_pc          = pc;
        id_rd          = rd;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_use_rs1     = u1;
        id_use_rs2     = u2;
        id_reg_write   = rw;
        id_result_src  = rsrc;
        id_mem_write   = mw;
        id_alu_src     = rsrc;
        id_branch      = 1'b0;
        id_alu_control = 3'b010;
        id_rd1         = 32'h1000_0000 | pc;
        id_rd2         = 32'h2000_0000 | pc;
        id_imm_ext     = 32'h3000_0000 | pc;
    endtask

    task automatic idle();
        id_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b1;
        drive_instr(32'h0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Reset state
        tick();
        tick();
        chk("rst_id_ready", {31'd0, id_ready}, 32'd0);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_rd", {28'd0, ex_rd}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_id_ready", {31'd0, id_ready}, 32'd1);

        // Streaming: four ADDs back to back
        for (int i = 0; i < 4; i++) begin
            drive_instr(32'(i * 4), 4'(i + 1), 4'(i), 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            chk("stream_id_ready", {31'd0, id_ready}, 32'd1);
            tick();
            chk("stream_ex_valid", {31'd0, ex_valid}, 32'd1);
            chk("stream_ex_pc", ex_pc, 32'(i * 4));
            chk("stream_ex_rd1", ex_rd1, 32'h1000_0000 | 32'(i * 4));
            chk("stream_ex_rd", {28'd0, ex_rd}, 32'(i + 1));
        end
        idle();
        tick();
        chk("drain_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("drain_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);

        // Load-use on rs1
        drive_instr(32'h10, 4'd3, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ldr_ex_result_src", {31'd0, ex_result_src}, 32'd1);
        drive_instr(32'h14, 4'd4, 4'd3, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_id_ready_stall", {31'd0, id_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("lu_id_ready_retry", {31'd0, id_ready}, 32'd1);
        tick();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_pc", ex_pc, 32'h14);

        // Same sequence, source not used: no stall
        idle();
        tick();
        drive_instr(32'h20, 4'd3, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_instr(32'h24, 4'd4, 4'd3, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("nouse_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("nouse_ex_pc", ex_pc, 32'h24);
        chk("nouse_ex_valid", {31'd0, ex_valid}, 32'd1);

        // Back-pressure for three cycles while full
        drive_instr(32'h28, 4'd6, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
            tick();
            chk("bp_ex_valid", {31'd0, ex_valid}, 32'd1);
            chk("bp_ex_pc", ex_pc, 32'h24);
            chk("bp_ex_rd2", ex_rd2, 32'h2000_0024);
            chk("bp_ex_reg_write", {31'd0, ex_reg_write}, 32'd1);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_resume_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("bp_resume_pc", ex_pc, 32'h28);
        chk("bp_resume_valid", {31'd0, ex_valid}, 32'd1);
        idle();
        tick();
        chk("bp_no_dup_valid", {31'd0, ex_valid}, 32'd0);

        // Flush beats back-pressure and an active hazard
        drive_instr(32'h30, 4'd7, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("fl_pre_mem_write", {31'd0, ex_mem_write}, 32'd1);
        drive_instr(32'h34, 4'd8, 4'd7, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        ex_ready = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_ex_mem_write", {31'd0, ex_mem_write}, 32'd0);
        flush = 1'b0;
        ex_ready = 1'b1;
        idle();
        tick();
        chk("fl_discarded", {31'd0, ex_valid}, 32'd0);

        // Register zero is not special: load to r0 then use of rs2=r0 stalls
        drive_instr(32'h38, 4'd0, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_instr(32'h3C, 4'd5, 4'd1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("r0_id_ready_stall", {31'd0, id_ready}, 32'd0);
        tick();
        chk("r0_bubble_valid", {31'd0, ex_valid}, 32'd0);
        tick();
        chk("r0_add_pc", ex_pc, 32'h3C);

        // Reset mid-stream with a store in execute
        drive_instr(32'h40, 4'd2, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("mid_pre_mem_write", {31'd0, ex_mem_write}, 32'd1);
        drive_instr(32'h44, 4'd3, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        chk("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("mid_rst_ex_mem_write", {31'd0, ex_mem_write}, 32'd0);
        chk("mid_rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("mid_rst_ex_pc", ex_pc, 32'd0);
        chk("mid_rst_ex_imm", ex_imm_ext, 32'd0);
`ifdef DECODE_EXECUTE_PERF_EN
        chk("mid_rst_stall_cnt", perf_stall_cnt, 32'd0);
        chk("mid_rst_flush_cnt", perf_flush_cnt, 32'd0);
        chk("mid_rst_bubble_cnt", perf_bubble_cnt, 32'd0);
`endif
        rst = 1'b0;
        idle();
        tick();
        chk("post_rst_ex_valid", {31'd0, ex_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
